// File: rtl/fp_pkg.sv
// fp_pkg: binary32 field widths, constants and shared types for the FPU multiplier and divider.
package fp_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned QUO_W     = 27;
    localparam int unsigned REM_W     = 26;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned E_W       = 10;
    localparam int unsigned RMODE_W   = 3;
    localparam int unsigned LAST_ITER = 26;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_MAX   = 255;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [WORD_W-2:0] MAXFIN  = 31'h7F7F_FFFF;
    localparam logic [WORD_W-2:0] INF_MAG = 31'h7F80_0000;

    typedef enum logic [RMODE_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } div_state_e;

    typedef struct packed {
        logic ovrf;
        logic udrf;
        logic zer;
        logic inf;
        logic nan;
        logic dvz;
    } fp_flags_t;

endpackage

// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: start/valid request and result bus of the sequential divider.
interface fp_div_seq_if;
    import fp_pkg::*;

    logic                start;
    logic [WORD_W-1:0]   fp_X;
    logic [WORD_W-1:0]   fp_Y;
    logic [RMODE_W-1:0]  r_mode;
    logic                busy;
    logic                valid;
    logic [WORD_W-1:0]   fp_Z;
    logic                ovrf;
    logic                udrf;
    logic                zer;
    logic                inf;
    logic                nan;
    logic                dvz;

    modport master (
        output start, fp_X, fp_Y, r_mode,
        input  busy, valid, fp_Z, ovrf, udrf, zer, inf, nan, dvz
    );

    modport slave (
        input  start, fp_X, fp_Y, r_mode,
        output busy, valid, fp_Z, ovrf, udrf, zer, inf, nan, dvz
    );

endinterface

// File: rtl/fp_div_round.sv
// fp_div_round: combinational normalize, round and exponent range check of a raw quotient.
module fp_div_round
    import fp_pkg::*;
(
    input  logic [QUO_W-1:0]      q,
    input  logic                  sticky,
    input  logic                  s,
    input  logic [RMODE_W-1:0]    r_mode,
    input  logic signed [E_W-1:0] ediff,
    output logic [WORD_W-1:0]     fp_z_c,
    output fp_flags_t             flags_c
);

    logic                  sh;
    logic                  g;
    logic                  st;
    logic                  inc;
    logic                  carry;
    logic                  max_fin;
    logic [QUO_W-1:0]      qn;
    logic [MANT_W-1:0]     sig;
    logic [FRAC_W-1:0]     frac;
    logic signed [E_W-1:0] e;

    always_comb begin
        fp_z_c  = '0;
        flags_c = '0;

        sh  = ~q[QUO_W-1];
        qn  = sh ? {q[QUO_W-2:0], 1'b0} : q;
        sig = qn[QUO_W-1 -: MANT_W];
        g   = qn[2];
        st  = (|qn[1:0]) | sticky;

        case (r_mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = s & (g | st);
            RUP:     inc = ~s & (g | st);
            RMM:     inc = g;
            default: inc = g & (st | sig[0]);
        endcase

        // An all-ones significand rounds up to 1.0: fraction wraps to zero, exponent bumps
        carry = inc & (&sig);
        frac  = sig[FRAC_W-1:0] + FRAC_W'(inc);
        e     = ediff + $signed(E_W'(BIAS)) - $signed(E_W'(sh)) + $signed(E_W'(carry));

        max_fin = (r_mode == RTZ) | ((r_mode == RDN) & ~s) | ((r_mode == RUP) & s);

        if (e >= $signed(E_W'(EXP_MAX))) begin
            flags_c.ovrf = 1'b1;
            flags_c.inf  = ~max_fin;
            fp_z_c       = max_fin ? {s, MAXFIN} : {s, INF_MAG};
        end else if (e <= $signed(E_W'(0))) begin
            flags_c.udrf = 1'b1;
            flags_c.zer  = 1'b1;
            fp_z_c       = {s, (WORD_W-1)'(0)};
        end else begin
            fp_z_c = {s, e[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential binary32 divider, radix-2 restoring, one quotient bit per cycle.
// Defining FP_DIV_SVA_EN compiles in embedded assertions.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fp_div_seq_if.slave bus
);

    div_state_e            state_q;
    div_state_e            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [REM_W-1:0]      rem_q;
    logic [MANT_W-1:0]     my_q;
    logic [QUO_W-1:0]      q_q;
    logic                  s_q;
    logic [RMODE_W-1:0]    rmode_q;
    logic signed [E_W-1:0] ediff_q;
    logic                  special_q;
    logic [WORD_W-1:0]     spec_z_q;
    fp_flags_t             spec_flags_q;
    logic [WORD_W-1:0]     fp_z_q;
    fp_flags_t             flags_q;
    logic                  busy_q;
    logic                  valid_q;

    logic [EXP_W-1:0]      x_exp;
    logic [EXP_W-1:0]      y_exp;
    logic                  x_zero, x_inf, x_nan;
    logic                  y_zero, y_inf, y_nan;
    logic                  s_c;
    logic                  special_c;
    logic [WORD_W-1:0]     spec_z_c;
    fp_flags_t             spec_flags_c;
    logic [REM_W:0]        diff_c;
    logic                  qbit_c;
    logic [REM_W-1:0]      rem_nxt_c;
    logic [WORD_W-1:0]     rnd_z_c;
    fp_flags_t             rnd_flags_c;

    // Operand classification and special-case result; subnormals count as zero
    always_comb begin
        x_exp  = bus.fp_X[WORD_W-2 -: EXP_W];
        y_exp  = bus.fp_Y[WORD_W-2 -: EXP_W];
        x_zero = (x_exp == '0);
        y_zero = (y_exp == '0);
        x_nan  = (x_exp == '1) & (|bus.fp_X[FRAC_W-1:0]);
        y_nan  = (y_exp == '1) & (|bus.fp_Y[FRAC_W-1:0]);
        x_inf  = (x_exp == '1) & ~(|bus.fp_X[FRAC_W-1:0]);
        y_inf  = (y_exp == '1) & ~(|bus.fp_Y[FRAC_W-1:0]);
        s_c    = bus.fp_X[WORD_W-1] ^ bus.fp_Y[WORD_W-1];

        special_c    = 1'b1;
        spec_flags_c = '0;
        spec_z_c     = {s_c, (WORD_W-1)'(0)};
        if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
            spec_z_c         = QNAN;
            spec_flags_c.nan = 1'b1;
        end else if (y_zero & ~x_inf) begin
            spec_z_c         = {s_c, INF_MAG};
            spec_flags_c.inf = 1'b1;
            spec_flags_c.dvz = 1'b1;
        end else if (x_inf) begin
            spec_z_c         = {s_c, INF_MAG};
            spec_flags_c.inf = 1'b1;
        end else if (x_zero | y_inf) begin
            spec_flags_c.zer = 1'b1;
        end else begin
            special_c = 1'b0;
        end
    end

    // One restoring step: subtract the divisor when it fits
    always_comb begin
        diff_c    = {1'b0, rem_q} - {3'b0, my_q};
        qbit_c    = ~diff_c[REM_W];
        rem_nxt_c = qbit_c ? diff_c[REM_W-1:0] : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Specials pass through ROUND so their valid lands in the same slot relative to the result register
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = special_c ? ROUND : DIV;
            DIV:     if (cnt_q == CNT_W'(LAST_ITER)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            rem_q        <= '0;
            my_q         <= '0;
            q_q          <= '0;
            s_q          <= 1'b0;
            rmode_q      <= '0;
            ediff_q      <= '0;
            special_q    <= 1'b0;
            spec_z_q     <= '0;
            spec_flags_q <= '0;
            fp_z_q       <= '0;
            flags_q      <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        rem_q        <= {2'b0, 1'b1, bus.fp_X[FRAC_W-1:0]};
                        my_q         <= {1'b1, bus.fp_Y[FRAC_W-1:0]};
                        q_q          <= '0;
                        cnt_q        <= '0;
                        s_q          <= s_c;
                        rmode_q      <= bus.r_mode;
                        ediff_q      <= $signed({2'b0, x_exp}) - $signed({2'b0, y_exp});
                        special_q    <= special_c;
                        spec_z_q     <= spec_z_c;
                        spec_flags_q <= spec_flags_c;
                        flags_q      <= '0;
                    end
                end
                DIV: begin
                    q_q   <= {q_q[QUO_W-2:0], qbit_c};
                    rem_q <= rem_nxt_c << 1;
                    cnt_q <= (cnt_q == CNT_W'(LAST_ITER)) ? '0 : cnt_q + CNT_W'(1);
                end
                ROUND: begin
                    fp_z_q  <= special_q ? spec_z_q : rnd_z_c;
                    flags_q <= special_q ? spec_flags_q : rnd_flags_c;
                end
                default: ;
            endcase
        end
    end

    fp_div_round u_round (
        .q       (q_q),
        .sticky  (|rem_q),
        .s       (s_q),
        .r_mode  (rmode_q),
        .ediff   (ediff_q),
        .fp_z_c  (rnd_z_c),
        .flags_c (rnd_flags_c)
    );

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.fp_Z  = fp_z_q;
    assign bus.ovrf  = flags_q.ovrf;
    assign bus.udrf  = flags_q.udrf;
    assign bus.zer   = flags_q.zer;
    assign bus.inf   = flags_q.inf;
    assign bus.nan   = flags_q.nan;
    assign bus.dvz   = flags_q.dvz;

`ifdef FP_DIV_SVA_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt_q <= CNT_W'(LAST_ITER))
                else $error("fp_div_seq: iteration counter out of range");
            if (state_q == ROUND && !special_q) begin
                assert (q_q[QUO_W-1] | q_q[QUO_W-2])
                    else $error("fp_div_seq: quotient not normalizable");
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) valid_q |=> !valid_q);
    assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> !(busy_q || valid_q));
    assert property (@(posedge clk) disable iff (rst) $onehot0({flags_q.nan, flags_q.inf, flags_q.zer}));
`else
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vectors for fp_div_seq with hand-computed results and latencies.
module tb_fp_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {26'b0, bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan, bus.dvz};
    endfunction

    // Flags packed as {ovrf,udrf,zer,inf,nan,dvz}; poke pulses a junk start in that cycle
    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] m, input logic [31:0] ez, input logic [5:0] ef,
                       input int elat, input int poke);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.fp_X   = x;
        bus.fp_Y   = y;
        bus.r_mode = m;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
        chk({tag, "_flagclr"}, flags_now(), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            if (c == poke) begin
                bus.fp_X  = 32'h3F80_0000;
                bus.fp_Y  = 32'h4040_0000;
                bus.start = 1'b1;
            end
            if (bus.valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_z"}, bus.fp_Z, ez);
        chk({tag, "_flags"}, flags_now(), {26'b0, ef});
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_vpulse"}, 32'(bus.valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int nv;
        bus.start  = 1'b0;
        bus.fp_X   = '0;
        bus.fp_Y   = '0;
        bus.r_mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_z", bus.fp_Z, 32'd0);
        chk("rst_flags", flags_now(), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);

        run("six_by_two",  32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 6'b000000, 29, 0);
        run("third_rne",   32'h3F80_0000, 32'h4040_0000, 3'b000, 32'h3EAA_AAAB, 6'b000000, 29, 0);
        run("third_rtz",   32'h3F80_0000, 32'h4040_0000, 3'b001, 32'h3EAA_AAAA, 6'b000000, 29, 0);
        run("third_rup",   32'h3F80_0000, 32'h4040_0000, 3'b011, 32'h3EAA_AAAB, 6'b000000, 29, 0);
        run("nthird_rdn",  32'hBF80_0000, 32'h4040_0000, 3'b010, 32'hBEAA_AAAB, 6'b000000, 29, 0);
        run("third_rdn",   32'h3F80_0000, 32'h4040_0000, 3'b010, 32'h3EAA_AAAA, 6'b000000, 29, 0);
        run("third_rmm",   32'h3F80_0000, 32'h4040_0000, 3'b100, 32'h3EAA_AAAB, 6'b000000, 29, 0);
        run("third_bad",   32'h3F80_0000, 32'h4040_0000, 3'b111, 32'h3EAA_AAAB, 6'b000000, 29, 0);
        run("neg_six",     32'hC0C0_0000, 32'h4000_0000, 3'b000, 32'hC040_0000, 6'b000000, 29, 0);

        run("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 3'b000, 32'h7F80_0000, 6'b000101, 2, 0);
        run("zero_zero",   32'h0000_0000, 32'h0000_0000, 3'b000, 32'h7FC0_0000, 6'b000010, 2, 0);
        run("subn_x",      32'h0040_0000, 32'h3F80_0000, 3'b000, 32'h0000_0000, 6'b001000, 2, 0);
        run("inf_by_two",  32'h7F80_0000, 32'h4000_0000, 3'b000, 32'h7F80_0000, 6'b000100, 2, 0);
        run("inf_by_zero", 32'h7F80_0000, 32'h0000_0000, 3'b000, 32'h7F80_0000, 6'b000100, 2, 0);
        run("inf_inf",     32'h7F80_0000, 32'hFF80_0000, 3'b000, 32'h7FC0_0000, 6'b000010, 2, 0);
        run("two_by_ninf", 32'h4000_0000, 32'hFF80_0000, 3'b000, 32'h8000_0000, 6'b001000, 2, 0);
        run("nan_x",       32'h7FC0_0001, 32'h3F80_0000, 3'b000, 32'h7FC0_0000, 6'b000010, 2, 0);

        run("ovf_rne",     32'h7F00_0000, 32'h3E80_0000, 3'b000, 32'h7F80_0000, 6'b100100, 29, 0);
        run("ovf_rtz",     32'h7F00_0000, 32'h3E80_0000, 3'b001, 32'h7F7F_FFFF, 6'b100000, 29, 0);
        run("ovf_rup",     32'h7F00_0000, 32'h3E80_0000, 3'b011, 32'h7F80_0000, 6'b100100, 29, 0);
        run("novf_rup",    32'hFF00_0000, 32'h3E80_0000, 3'b011, 32'hFF7F_FFFF, 6'b100000, 29, 0);
        run("udf_pos",     32'h0080_0000, 32'h4000_0000, 3'b000, 32'h0000_0000, 6'b011000, 29, 0);
        run("udf_neg",     32'h8080_0000, 32'h4000_0000, 3'b000, 32'h8000_0000, 6'b011000, 29, 0);

        run("poke_busy",   32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 6'b000000, 29, 5);
        run("poke_valid",  32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 6'b000000, 29, 29);

        @(negedge clk);
        bus.fp_X   = 32'h3F80_0000;
        bus.fp_Y   = 32'h4040_0000;
        bus.r_mode = 3'b000;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_z", bus.fp_Z, 32'd0);
        chk("abort_flags", flags_now(), 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid) nv++;
        end
        chk("abort_novalid", 32'(nv), 32'd0);

        run("after_abort", 32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 6'b000000, 29, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
